// File: rtl/dsp_share_scheduler.sv
// Round-robin scheduler that time-shares one pipelined ((d-a)*b)+c DSP among NREQ requesters.
// Each op is tagged with its requester index and the result is written back to that requester's response slot.
module dsp_share_scheduler #(
  parameter int WIDTH   = 10,
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*WIDTH-1:0] req_c,
  input  logic [NREQ*WIDTH-1:0] req_d,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [NREQ*WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0]      dsp_a,
  output logic [WIDTH-1:0]      dsp_b,
  output logic [WIDTH-1:0]      dsp_c,
  output logic [WIDTH-1:0]      dsp_d,
  input  logic [WIDTH-1:0]      dsp_out,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]    outstanding;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    drain;
  logic [NREQ-1:0]    rsp_valid_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_next;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [LATENCY-1:0] vld_p;
  logic [IDX_W-1:0]   idx_p [LATENCY];

  // Grants are suppressed combinationally while reset is held.
  assign eligible = req_valid & ~outstanding & {NREQ{rst_n}};
  assign drain    = rsp_valid & rsp_ready;

  // Scan offsets from high to low so the nearest eligible index after rr_ptr wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (eligible[IDX_W'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign rr_next = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign dsp_a = gnt_vld ? req_a[gnt_idx*WIDTH +: WIDTH] : '0;
  assign dsp_b = gnt_vld ? req_b[gnt_idx*WIDTH +: WIDTH] : '0;
  assign dsp_c = gnt_vld ? req_c[gnt_idx*WIDTH +: WIDTH] : '0;
  assign dsp_d = gnt_vld ? req_d[gnt_idx*WIDTH +: WIDTH] : '0;

  assign busy = (|outstanding) | (|vld_p);

  always_comb begin
    rsp_valid_nxt = rsp_valid & ~drain;
    if (vld_p[LATENCY-1]) rsp_valid_nxt[idx_p[LATENCY-1]] = 1'b1;
  end

  // Stage p0: accept, tag capture alongside the DSP operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      rr_ptr      <= '0;
      vld_p       <= '0;
      for (int s = 0; s < LATENCY; s++) idx_p[s] <= '0;
      rsp_valid   <= '0;
    end else begin
      outstanding <= (outstanding & ~drain) | req_ready;
      if (gnt_vld) rr_ptr <= rr_next;
      vld_p[0]  <= gnt_vld;
      idx_p[0]  <= gnt_idx;
      // Stages p1..p(LATENCY-1): tag pipe tracking the DSP registers
      for (int s = 1; s < LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
        idx_p[s] <= idx_p[s-1];
      end
      rsp_valid <= rsp_valid_nxt;
    end
  end

  // Writeback stage: tag at pipe end lines up with dsp_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (vld_p[LATENCY-1]) begin
      rsp_data[idx_p[LATENCY-1]*WIDTH +: WIDTH] <= dsp_out;
    end
  end

endmodule
